ysyx_22041211_muldiv_seq: RTL and testbench

Iterative multi-cycle sequencer that time-shares the core's 32-bit ALU to execute MUL, DIVU and REMU.
- MUL: shift-and-add, issuing ALU ADD every iteration.
- DIVU/REMU: restoring division, issuing ALU SUB every iteration.
- Sits beside the EXU. It drives the ALU operand/control inputs while busy and takes the ALU result back.
- Valid/ready handshakes on both the request side and the result side.

---
 rtl/ysyx_22041211_muldiv_seq.sv | 199 +++++++++++++++++++
 tb/tb_ysyx_22041211_muldiv_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041211_muldiv_seq.sv
// Iterative MUL / DIVU / REMU sequencer that borrows the core ALU.
// MUL runs shift-and-add with ALU ADD. DIVU/REMU run restoring division
// with ALU SUB. Each operation takes one iteration per result bit.
module ysyx_22041211_muldiv_seq #(
    parameter int          DATA_LEN = 32,
    parameter logic [3:0]  OP_ADD   = 4'b0000,
    parameter logic [3:0]  OP_SUB   = 4'b0001
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [1:0]          op_i,
    input  logic [DATA_LEN-1:0] src1_i,
    input  logic [DATA_LEN-1:0] src2_i,
    input  logic                flush_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [DATA_LEN-1:0] result_o,
    output logic                busy_o,
    output logic [DATA_LEN-1:0] alu_src1_o,
    output logic [DATA_LEN-1:0] alu_src2_o,
    output logic [3:0]          alu_control_o,
    input  logic [DATA_LEN-1:0] alu_result_i
);

    localparam int CNT_W = $clog2(DATA_LEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OPC_MUL  = 2'b00,
        OPC_DIVU = 2'b01,
        OPC_REMU = 2'b10,
        OPC_RSVD = 2'b11
    } opc_t;

    state_t              state, state_nxt;
    opc_t                op_q;
    logic [CNT_W-1:0]    cnt;

    // Multiply working registers.
    logic [DATA_LEN-1:0] acc, mcand, mplier;
    // Divide working registers.
    logic [DATA_LEN-1:0] rem, quo, dvsr;

    logic                accept;
    logic                short_cut;
    logic                last_iter;
    logic                is_mul;

    logic [DATA_LEN-1:0] partial;
    logic                ge;
    logic [DATA_LEN-1:0] rem_nxt, quo_nxt;
    logic [DATA_LEN-1:0] short_result;
    logic [DATA_LEN-1:0] final_result;

    // flush_i wins over a request arriving in the same cycle.
    assign accept    = in_valid_i && in_ready_o && !flush_i;
    assign short_cut = (op_i == OPC_RSVD) ||
                       (((op_i == OPC_DIVU) || (op_i == OPC_REMU)) && (src2_i == '0));
    assign last_iter = (cnt == CNT_W'(DATA_LEN - 1));
    assign is_mul    = (op_q == OPC_MUL);

    // Restoring-division step: the ALU supplies the difference, the compare is local.
    always_comb begin
        partial      = {rem[DATA_LEN-2:0], quo[DATA_LEN-1]};
        ge           = rem[DATA_LEN-1] | (partial >= dvsr);
        rem_nxt      = ge ? alu_result_i : partial;
        quo_nxt      = {quo[DATA_LEN-2:0], ge};
        short_result = '0;
        if (op_i == OPC_DIVU) begin
            short_result = '1;
        end else if (op_i == OPC_REMU) begin
            short_result = src1_i;
        end
        case (op_q)
            OPC_MUL:  final_result = alu_result_i;
            OPC_DIVU: final_result = quo_nxt;
            default:  final_result = rem_nxt;
        endcase
    end

    // ALU drive: only active in RUN, otherwise parked at the reset values.
    always_comb begin
        alu_control_o = OP_ADD;
        alu_src1_o    = '0;
        alu_src2_o    = '0;
        if (state == S_RUN) begin
            if (is_mul) begin
                alu_control_o = OP_ADD;
                alu_src1_o    = acc;
                alu_src2_o    = mplier[0] ? mcand : '0;
            end else begin
                alu_control_o = OP_SUB;
                alu_src1_o    = partial;
                alu_src2_o    = dvsr;
            end
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
        state_nxt   = state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready_o = 1'b1;
                if (accept) begin
                    state_nxt = short_cut ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy_o = 1'b1;
                if (flush_i) begin
                    state_nxt = S_IDLE;
                end else if (last_iter) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy_o      = 1'b1;
                out_valid_o = 1'b1;
                if (flush_i || out_ready_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand latch, per-iteration update and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= OPC_MUL;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            result_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q   <= opc_t'(op_i);
                        cnt    <= '0;
                        acc    <= '0;
                        mcand  <= src1_i;
                        mplier <= src2_i;
                        rem    <= '0;
                        quo    <= src1_i;
                        dvsr   <= src2_i;
                        if (short_cut) begin
                            result_o <= short_result;
                        end
                    end
                end
                S_RUN: begin
                    if (!flush_i) begin
                        cnt <= cnt + CNT_W'(1);
                        if (is_mul) begin
                            acc    <= alu_result_i;
                            mcand  <= mcand << 1;
                            mplier <= mplier >> 1;
                        end else begin
                            rem <= rem_nxt;
                            quo <= quo_nxt;
                        end
                        if (last_iter) begin
                            result_o <= final_result;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041211_muldiv_seq.sv
// Self-checking bench for ysyx_22041211_muldiv_seq: directed and random
// operations scored against an arithmetic reference model.
module tb_ysyx_22041211_muldiv_seq;

    localparam int         DATA_LEN = 32;
    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam int         LAT_RUN  = DATA_LEN + 1;
    localparam int         LAT_SHORT = 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid_i;
    logic                in_ready_o;
    logic [1:0]          op_i;
    logic [DATA_LEN-1:0] src1_i, src2_i;
    logic                flush_i;
    logic                out_valid_o;
    logic                out_ready_i;
    logic [DATA_LEN-1:0] result_o;
    logic                busy_o;
    logic [DATA_LEN-1:0] alu_src1_o, alu_src2_o;
    logic [3:0]          alu_control_o;
    logic [DATA_LEN-1:0] alu_result_i;

    int n_cmp = 0;
    int n_err = 0;
    logic [DATA_LEN-1:0] exp_q[$];

    ysyx_22041211_muldiv_seq #(
        .DATA_LEN(DATA_LEN), .OP_ADD(OP_ADD), .OP_SUB(OP_SUB)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .op_i(op_i), .src1_i(src1_i), .src2_i(src2_i),
        .flush_i(flush_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .result_o(result_o), .busy_o(busy_o),
        .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o),
        .alu_control_o(alu_control_o), .alu_result_i(alu_result_i)
    );

    always #5 clk = ~clk;

    // The core ALU the sequencer borrows.
    assign alu_result_i = (alu_control_o == OP_ADD) ? alu_src1_o + alu_src2_o :
                          (alu_control_o == OP_SUB) ? alu_src1_o - alu_src2_o : '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        case (op)
            2'b00:   return p[31:0];
            2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] b);
        if (op == 2'b11 || (op != 2'b00 && b == 0)) return LAT_SHORT;
        return LAT_RUN;
    endfunction

    // Monitor: pops the scoreboard whenever a result is handed over.
    always @(negedge clk) begin
        if (!rst && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got %h expected none", result_o);
            end else begin
                check("result", result_o, exp_q.pop_front());
            end
        end
    end

    // Issue one request (caller sits just after a posedge, DUT in IDLE) and
    // wait for out_valid_o; lat counts negedges after the accepting edge.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
        int  n;
        bit  ctl_bad;
        logic [3:0] want_ctl;
        want_ctl   = (op == 2'b00) ? OP_ADD : OP_SUB;
        in_valid_i = 1'b1;
        op_i       = op;
        src1_i     = a;
        src2_i     = b;
        @(negedge clk);
        check("in_ready", in_ready_o, 1'b1);
        exp_q.push_back(ref_model(op, a, b));
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        src1_i     = $urandom;
        src2_i     = $urandom;
        op_i       = 2'($urandom);
        n       = 0;
        ctl_bad = 1'b0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (out_valid_o) break;
            if (busy_o && alu_control_o != want_ctl) ctl_bad = 1'b1;
        end
        lat = out_valid_o ? n : -1;
        check("alu_control_in_run", 32'(ctl_bad), 32'd0);
    endtask

    // Finish the handshake started by do_op (out_ready_i already high).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int lat;
        do_op(op, a, b, lat);
        check("latency", lat, ref_latency(op, b));
        @(posedge clk);
        #1;
    endtask

    // Start a DIVU 100/7 and abort it after the cnt=k update with flush or reset.
    task automatic abort_op(input int k, input bit use_rst);
        bit pulse;
        in_valid_i = 1'b1;
        op_i       = 2'b01;
        src1_i     = 32'd100;
        src2_i     = 32'd7;
        @(negedge clk);
        check("abort_in_ready", in_ready_o, 1'b1);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        repeat (k) @(posedge clk);
        #1;
        check("abort_busy_before", busy_o, 1'b1);
        if (use_rst) rst = 1'b1;
        else         flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        check("abort_out_valid", out_valid_o, 1'b0);
        check("abort_busy", busy_o, 1'b0);
        check("abort_in_ready_after", in_ready_o, 1'b1);
        if (use_rst) begin
            check("rst_result", result_o, 32'h0);
            check("rst_alu_ctl", alu_control_o, OP_ADD);
            check("rst_alu_src1", alu_src1_o, 32'h0);
            check("rst_alu_src2", alu_src2_o, 32'h0);
            @(posedge clk);
            #1;
            rst = 1'b0;
        end
        pulse = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid_o) pulse = 1'b1;
        end
        check("abort_no_pulse", 32'(pulse), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] held;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int          lat;
        bit          unstable;

        rst         = 1'b1;
        in_valid_i  = 1'b0;
        op_i        = 2'b00;
        src1_i      = '0;
        src2_i      = '0;
        flush_i     = 1'b0;
        out_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", in_ready_o, 1'b1);
        check("reset_out_valid", out_valid_o, 1'b0);
        check("reset_result", result_o, 32'h0);
        check("reset_busy", busy_o, 1'b0);
        check("reset_alu_ctl", alu_control_o, OP_ADD);
        check("reset_alu_src1", alu_src1_o, 32'h0);
        check("reset_alu_src2", alu_src2_o, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases, including top-bit and divide-by-zero paths.
        run_op(2'b00, 32'd7, 32'd6);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(2'b00, 32'h8000_0000, 32'd2);
        run_op(2'b01, 32'd100, 32'd7);
        run_op(2'b10, 32'd100, 32'd7);
        run_op(2'b01, 32'h8000_0000, 32'd3);
        run_op(2'b10, 32'h8000_0000, 32'd3);
        run_op(2'b01, 32'hFFFF_FFFF, 32'h8000_0001);
        run_op(2'b10, 32'hFFFF_FFFF, 32'h8000_0001);
        run_op(2'b01, 32'd5, 32'd0);
        run_op(2'b10, 32'd5, 32'd0);
        run_op(2'b11, 32'd123, 32'd456);

        // Backpressure: hold the result in DONE for five cycles.
        out_ready_i = 1'b0;
        do_op(2'b01, 32'd100, 32'd7, lat);
        check("bp_latency", lat, LAT_RUN);
        held     = result_o;
        unstable = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (!out_valid_o || result_o !== held || in_ready_o || !busy_o) unstable = 1'b1;
        end
        check("bp_stable", 32'(unstable), 32'd0);
        check("bp_held_value", held, 32'd14);
        @(posedge clk);
        #1;
        out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        check("bp_idle_out_valid", out_valid_o, 1'b0);
        check("bp_idle_in_ready", in_ready_o, 1'b1);
        run_op(2'b00, 32'd3, 32'd5);

        // Aborts, each followed by a fresh division.
        abort_op(10, 1'b0);
        run_op(2'b01, 32'd100, 32'd7);
        abort_op(20, 1'b1);
        run_op(2'b01, 32'd100, 32'd7);

        // Randomised operations.
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'h0;
                1:       rb = $urandom_range(1, 1000);
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb);
        end

        repeat (3) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
